// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg: opcodes, default sizes and immediate decoders shared by the predictor
package gshare_predictor_pkg;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam int PHT_IDX_W_DEF = 7;
  localparam int GHR_W_DEF = 6;
  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if: fetch-side predict and ROB-side commit signals of the predictor
interface gshare_predictor_if #(parameter int GHR_W = 6);
  localparam int GW = GHR_W > 0 ? GHR_W : 1;
  logic if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic predict_res;
  logic [31:0] predict_pc;
  logic [GW-1:0] predict_ghr;
  logic ROB_valid;
  logic [31:0] commit_pc;
  logic [GW-1:0] commit_ghr;
  logic real_result;
  logic commit_mispredict;
  modport master (
    output if_valid, if_pc, if_inst, ROB_valid, commit_pc, commit_ghr, real_result, commit_mispredict,
    input predict_res, predict_pc, predict_ghr
  );
  modport slave (
    input if_valid, if_pc, if_inst, ROB_valid, commit_pc, commit_ghr, real_result, commit_mispredict,
    output predict_res, predict_pc, predict_ghr
  );
endinterface

// File: rtl/gshare_predictor_sat_counter_update.sv
// sat_counter_update: next value of a saturating up/down counter
module sat_counter_update #(parameter int CNT_W = 2) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);
  assign cnt_o = taken_i ? (&cnt_i ? cnt_i : cnt_i + 1'b1) : (|cnt_i ? cnt_i - 1'b1 : cnt_i);
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: PHT of saturating counters indexed by PC xor speculative global history
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int PHT_IDX_W = PHT_IDX_W_DEF,
  parameter int CNT_W = 2,
  parameter int GHR_W = GHR_W_DEF,
  parameter int USE_GHR = 1
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  gshare_predictor_if.slave bp
);
  localparam int N = 1 << PHT_IDX_W;
  localparam int GW = GHR_W > 0 ? GHR_W : 1;
  localparam logic [CNT_W-1:0] WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  logic [CNT_W-1:0] pht_q [N];
  logic [CNT_W-1:0] cnt_d;
  logic [GW-1:0] ghr_q, ghr_d;
  logic [PHT_IDX_W-1:0] fidx, cidx;
  logic is_b, is_jal, taken;
  assign fidx = bp.if_pc[PHT_IDX_W+1:2] ^ (USE_GHR != 0 ? PHT_IDX_W'(ghr_q) : '0);
  assign cidx = bp.commit_pc[PHT_IDX_W+1:2] ^ (USE_GHR != 0 ? PHT_IDX_W'(bp.commit_ghr) : '0);
  assign is_b = bp.if_inst[6:0] == OP_B_TYPE;
  assign is_jal = bp.if_inst[6:0] == OP_JAL;
  assign taken = pht_q[fidx][CNT_W-1];
  assign bp.predict_res = is_b ? taken : is_jal;
  assign bp.predict_pc = bp.if_pc + (is_b && taken ? b_imm(bp.if_inst) : is_jal ? j_imm(bp.if_inst) : 32'd4);
  assign bp.predict_ghr = ghr_q;
  sat_counter_update #(.CNT_W(CNT_W)) u_cnt (
    .cnt_i(pht_q[cidx]),
    .taken_i(bp.real_result),
    .cnt_o(cnt_d)
  );
  // a mispredict rebuilds history from the ROB snapshot and drops the wrong-path fetch shift
  always_comb begin
    ghr_d = bp.ROB_valid && bp.commit_mispredict ? GW'({bp.commit_ghr, bp.real_result}) :
            bp.if_valid && is_b ? GW'({ghr_q, bp.predict_res}) : ghr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < N; i++) pht_q[i] <= WNT;
    else if (rdy && bp.ROB_valid) pht_q[cidx] <= cnt_d;
  end
  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else if (rdy) ghr_q <= GHR_W > 0 ? ghr_d : '0;
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: gshare and bimodal builds checked against a table-level reference model
module tb_gshare_predictor;
  logic clk = 1'b0;
  logic rst, rdy;
  always #5 clk = ~clk;
  logic valid, rv, rr, mis;
  logic [31:0] pc, inst, cpc;
  logic [5:0] cg;
  int kind, imm;
  int checks = 0;
  int errors = 0;
  int pht[2][128];
  int ghr[2];
  gshare_predictor_if #(.GHR_W(6)) g_if ();
  gshare_predictor_if #(.GHR_W(6)) b_if ();
  assign g_if.if_valid = valid;
  assign g_if.if_pc = pc;
  assign g_if.if_inst = inst;
  assign g_if.ROB_valid = rv;
  assign g_if.commit_pc = cpc;
  assign g_if.commit_ghr = cg;
  assign g_if.real_result = rr;
  assign g_if.commit_mispredict = mis;
  assign b_if.if_valid = valid;
  assign b_if.if_pc = pc;
  assign b_if.if_inst = inst;
  assign b_if.ROB_valid = rv;
  assign b_if.commit_pc = cpc;
  assign b_if.commit_ghr = cg;
  assign b_if.real_result = rr;
  assign b_if.commit_mispredict = mis;
  logic res_o[2];
  logic [31:0] pc_o[2];
  logic [5:0] ghr_o[2];
  assign res_o[0] = g_if.predict_res;
  assign res_o[1] = b_if.predict_res;
  assign pc_o[0] = g_if.predict_pc;
  assign pc_o[1] = b_if.predict_pc;
  assign ghr_o[0] = g_if.predict_ghr;
  assign ghr_o[1] = b_if.predict_ghr;
  gshare_predictor #(.USE_GHR(1)) dut_g (.clk(clk), .rst(rst), .rdy(rdy), .bp(g_if));
  gshare_predictor #(.USE_GHR(0)) dut_b (.clk(clk), .rst(rst), .rdy(rdy), .bp(b_if));
  function automatic logic [31:0] enc(int kd, int im);
    logic [31:0] m, x;
    m = im;
    x = $urandom;
    x[6:0] = 7'b0010011;
    if (kd == 1) return {m[12], m[10:5], 5'd3, 5'd2, 3'b000, m[4:1], m[11], 7'b1100011};
    if (kd == 2) return {m[20], m[10:1], m[11], m[19:12], 5'd1, 7'b1101111};
    return x;
  endfunction
  function automatic int idx(int k, logic [31:0] p, int g);
    return (int'(p >> 2) ^ (k == 0 ? g : 0)) & 127;
  endfunction
  function automatic logic mres(int k);
    return kind == 1 ? pht[k][idx(k, pc, ghr[k])] >= 2 : kind == 2;
  endfunction
  function automatic logic [31:0] mpc(int k);
    return (kind == 2 || (kind == 1 && mres(k))) ? pc + 32'(imm) : pc + 32'd4;
  endfunction
  task automatic fetch(logic v, logic [31:0] p, int kd, int im);
    valid = v;
    pc = p;
    kind = kd;
    imm = im;
    inst = enc(kd, im);
  endtask
  task automatic commit(logic v, logic [31:0] p, logic [5:0] g, logic r, logic m);
    rv = v;
    cpc = p;
    cg = g;
    rr = r;
    mis = m;
  endtask
  task automatic tick();
    int ng[2];
    int c;
    logic r;
    for (int k = 0; k < 2; k++) begin
      r = mres(k);
      ng[k] = ghr[k];
      if (rst) begin
        for (int i = 0; i < 128; i++) pht[k][i] = 1;
        ng[k] = 0;
      end else if (rdy) begin
        if (rv) begin
          c = idx(k, cpc, int'(cg));
          pht[k][c] = rr ? (pht[k][c] < 3 ? pht[k][c] + 1 : 3) : (pht[k][c] > 0 ? pht[k][c] - 1 : 0);
        end
        if (rv && mis) ng[k] = ((int'(cg) << 1) | int'(rr)) & 63;
        else if (valid && kind == 1) ng[k] = ((ghr[k] << 1) | int'(r)) & 63;
      end
    end
    @(posedge clk);
    #1;
    ghr = ng;
  endtask
  task automatic test_reset();
    rdy = 1'b0;
    rst = 1'b1;
    fetch(1'b1, 32'h100, 1, 16);
    commit(1'b1, 32'h100, 6'd0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    commit(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    fetch(1'b0, 32'h100, 1, 16);
    #1;
    checks++; if (res_o[0] !== 1'b0) begin $display("FAIL reset_res got %b want 0", res_o[0]); errors++; end
    checks++; if (pc_o[0] !== 32'h104) begin $display("FAIL reset_pc got %h want 104", pc_o[0]); errors++; end
    checks++; if (ghr_o[0] !== 6'd0) begin $display("FAIL reset_ghr got %b want 0", ghr_o[0]); errors++; end
    fetch(1'b1, 32'h100, 0, 0);
    #1;
    checks++; if (res_o[1] !== 1'b0 || pc_o[1] !== 32'h104) begin $display("FAIL reset_plain got %b/%h want 0/104", res_o[1], pc_o[1]); errors++; end
  endtask
  task automatic test_train();
    fetch(1'b0, 32'h100, 1, 16);
    commit(1'b1, 32'h100, 6'd0, 1'b1, 1'b0);
    tick();
    tick();
    #1;
    checks++; if (res_o[0] !== 1'b1 || pc_o[0] !== 32'h110) begin $display("FAIL train_taken got %b/%h want 1/110", res_o[0], pc_o[0]); errors++; end
    tick();
    #1;
    checks++; if (res_o[0] !== 1'b1) begin $display("FAIL sat_high got %b want 1", res_o[0]); errors++; end
    commit(1'b1, 32'h100, 6'd0, 1'b0, 1'b0);
    repeat (4) tick();
    #1;
    checks++; if (res_o[0] !== 1'b0 || pc_o[0] !== 32'h104) begin $display("FAIL train_nt got %b/%h want 0/104", res_o[0], pc_o[0]); errors++; end
    tick();
    #1;
    checks++; if (res_o[0] !== 1'b0) begin $display("FAIL sat_low got %b want 0", res_o[0]); errors++; end
    commit(1'b1, 32'h100, 6'd0, 1'b1, 1'b0);
    tick();
    #1;
    checks++; if (res_o[0] !== 1'b0) begin $display("FAIL sat_low_inc got %b want 0", res_o[0]); errors++; end
    commit(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
  endtask
  task automatic test_ghr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch(1'b0, 32'h100, 1, 16);
    commit(1'b1, 32'h100, 6'd0, 1'b1, 1'b0);
    tick();
    tick();
    commit(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    fetch(1'b1, 32'h100, 1, 16);
    tick();
    tick();
    fetch(1'b1, 32'h108, 1, 16);
    tick();
    fetch(1'b0, 32'h100, 1, 16);
    #1;
    checks++; if (ghr_o[0] !== 6'b000101) begin $display("FAIL ghr_shift got %b want 000101", ghr_o[0]); errors++; end
    checks++; if (res_o[0] !== 1'b0) begin $display("FAIL ghr_index got %b want 0", res_o[0]); errors++; end
    checks++; if (res_o[1] !== 1'b1) begin $display("FAIL bimodal_index got %b want 1", res_o[1]); errors++; end
    commit(1'b1, 32'h100, 6'b000101, 1'b1, 1'b0);
    tick();
    tick();
    commit(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    #1;
    checks++; if (res_o[0] !== 1'b1 || pc_o[0] !== 32'h110) begin $display("FAIL commit_index got %b/%h want 1/110", res_o[0], pc_o[0]); errors++; end
  endtask
  task automatic test_mispredict();
    fetch(1'b1, 32'h100, 1, 16);
    commit(1'b1, 32'h300, 6'b000011, 1'b0, 1'b1);
    tick();
    commit(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    fetch(1'b0, 32'h100, 1, 16);
    #1;
    checks++; if (ghr_o[0] !== 6'b000110) begin $display("FAIL mispredict_g got %b want 000110", ghr_o[0]); errors++; end
    checks++; if (ghr_o[1] !== 6'b000110) begin $display("FAIL mispredict_b got %b want 000110", ghr_o[1]); errors++; end
  endtask
  task automatic test_rdy();
    rdy = 1'b0;
    fetch(1'b1, 32'h10C, 1, 16);
    commit(1'b1, 32'h100, 6'b000101, 1'b0, 1'b1);
    tick();
    tick();
    #1;
    checks++; if (ghr_o[0] !== 6'b000110) begin $display("FAIL rdy_ghr got %b want 000110", ghr_o[0]); errors++; end
    checks++; if (res_o[0] !== 1'b1) begin $display("FAIL rdy_pht got %b want 1", res_o[0]); errors++; end
    rdy = 1'b1;
    commit(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    tick();
    #1;
    checks++; if (ghr_o[0] !== 6'b001101) begin $display("FAIL rdy_resume got %b want 001101", ghr_o[0]); errors++; end
  endtask
  task automatic test_jal();
    fetch(1'b1, 32'h200, 2, -8);
    #1;
    checks++; if (res_o[0] !== 1'b1 || pc_o[0] !== 32'h1F8) begin $display("FAIL jal got %b/%h want 1/1f8", res_o[0], pc_o[0]); errors++; end
    tick();
    #1;
    checks++; if (ghr_o[0] !== 6'b001101) begin $display("FAIL jal_ghr got %b want 001101", ghr_o[0]); errors++; end
  endtask
  task automatic test_random();
    logic r;
    logic [31:0] p;
    for (int n = 0; n < 400; n++) begin
      rdy = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 63) == 0;
      kind = $urandom_range(0, 2);
      fetch(1'($urandom), {22'd0, 8'($urandom), 2'b00}, kind,
            kind == 2 ? (int'($urandom_range(0, 1048575)) - 524288) * 2 : (int'($urandom_range(0, 4095)) - 2048) * 2);
      commit(1'($urandom), {22'd0, 8'($urandom), 2'b00}, 6'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        r = mres(k);
        p = mpc(k);
        checks++; if (res_o[k] !== r) begin $display("FAIL rand_res[%0d] n=%0d got %b want %b", k, n, res_o[k], r); errors++; end
        checks++; if (pc_o[k] !== p) begin $display("FAIL rand_pc[%0d] n=%0d got %h want %h", k, n, pc_o[k], p); errors++; end
        checks++; if (ghr_o[k] !== 6'(ghr[k])) begin $display("FAIL rand_ghr[%0d] n=%0d got %b want %b", k, n, ghr_o[k], 6'(ghr[k])); errors++; end
      end
      tick();
    end
    rst = 1'b0;
    rdy = 1'b1;
  endtask
  initial begin
    test_reset();
    test_train();
    test_ghr();
    test_mispredict();
    test_rdy();
    test_jal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
